// File: rtl/microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_timer_ctrl
//  Purpose  : Keypad entry, tick gating and cook/pause/done sequencing for a
//             three-digit (M:SS) countdown datapath.
//  Revision : 1.0
// ============================================================================
module microwave_timer_ctrl #(
    parameter int DONE_TICKS = 3,
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       tick,
    input  logic       counter_zero,
    output logic [3:0] cnt_data,
    output logic       cnt_loadn,
    output logic       cnt_clrn,
    output logic       cnt_enable,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int                c_CNT_W    = $clog2(MAX_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]         c_LAST_BEEP = 4'(DONE_TICKS - 1);

    state_t              r_state;
    logic [3:0]          r_s0;
    logic [3:0]          r_s1;
    logic [3:0]          r_s2;
    logic [c_CNT_W-1:0]  r_count;
    logic [3:0]          r_beep_cnt;
    logic [3:0]          r_cnt_data;
    logic                r_cnt_loadn;
    logic                r_cnt_clrn;
    logic                r_mag_on;
    logic                r_beep;

    // One event per cycle survives: clear > door open > stop > start > key.
    logic w_door_open;
    logic w_ev_stop;
    logic w_ev_start;
    logic w_ev_key;
    logic w_key_ok;
    logic w_done_end;
    logic w_go_idle;
    logic w_unused_s2;

    assign w_door_open = ~clear & ~door_closed;
    assign w_ev_stop   = ~clear & door_closed & stop;
    assign w_ev_start  = ~clear & door_closed & ~stop & start;
    assign w_ev_key    = ~clear & door_closed & ~stop & ~start & key_valid;

    // The digit currently in s0 becomes seconds-tens after the shift.
    assign w_key_ok = w_ev_key
                    & ((r_state == ST_IDLE) | (r_state == ST_ENTRY))
                    & (key_data <= 4'd9)
                    & (r_count < c_MAX_CNT)
                    & (r_s0 <= 4'd5);

    assign w_done_end = (r_state == ST_DONE) & tick & (r_beep_cnt == c_LAST_BEEP);

    assign w_go_idle = clear
                     | (w_ev_stop & ((r_state == ST_ENTRY) | (r_state == ST_PAUSED)
                                     | (r_state == ST_DONE)))
                     | ((r_state == ST_DONE) & (w_ev_start | w_ev_key))
                     | w_done_end;

    assign w_unused_s2 = ^r_s2;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_s0        <= 4'd0;
            r_s1        <= 4'd0;
            r_s2        <= 4'd0;
            r_count     <= '0;
            r_beep_cnt  <= 4'd0;
            r_cnt_data  <= 4'd0;
            r_cnt_loadn <= 1'b1;
            r_cnt_clrn  <= 1'b0;
            r_mag_on    <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_cnt_loadn <= 1'b1;
            r_cnt_clrn  <= 1'b1;
            if (w_go_idle) begin
                r_state    <= ST_IDLE;
                r_cnt_clrn <= 1'b0;
                r_s0       <= 4'd0;
                r_s1       <= 4'd0;
                r_s2       <= 4'd0;
                r_count    <= '0;
                r_beep_cnt <= 4'd0;
                r_mag_on   <= 1'b0;
                r_beep     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_ENTRY: begin
                        if (w_key_ok) begin
                            r_state     <= ST_ENTRY;
                            r_cnt_data  <= key_data;
                            r_cnt_loadn <= 1'b0;
                            r_s2        <= r_s1;
                            r_s1        <= r_s0;
                            r_s0        <= key_data;
                            r_count     <= r_count + c_CNT_ONE;
                        end else if ((r_state == ST_ENTRY) & w_ev_start & ~counter_zero) begin
                            r_state  <= ST_COOK;
                            r_mag_on <= 1'b1;
                        end
                    end
                    ST_COOK: begin
                        if (w_door_open | w_ev_stop) begin
                            r_state  <= ST_PAUSED;
                            r_mag_on <= 1'b0;
                        end else if (counter_zero) begin
                            r_state    <= ST_DONE;
                            r_mag_on   <= 1'b0;
                            r_beep     <= 1'b1;
                            r_beep_cnt <= 4'd0;
                        end
                    end
                    ST_PAUSED: begin
                        if (w_ev_start) begin
                            r_state  <= ST_COOK;
                            r_mag_on <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (tick) begin
                            r_beep_cnt <= r_beep_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_mag_on <= 1'b0;
                        r_beep   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gated combinationally so a tick arriving with a pause request still counts.
    assign cnt_enable = (r_state == ST_COOK) & tick & ~counter_zero;

    assign cnt_data  = r_cnt_data;
    assign cnt_loadn = r_cnt_loadn;
    assign cnt_clrn  = r_cnt_clrn;
    assign mag_on    = r_mag_on;
    assign beep      = r_beep;
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microwave_timer_ctrl
//  Purpose  : Directed and randomized stimulus against a behavioural model of
//             the microwave timer controller.
//  Revision : 1.0
// ============================================================================
module tb_microwave_timer_ctrl;

    localparam int DONE_TICKS = 3;
    localparam int MAX_DIGITS = 3;

    logic       clk;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_data;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       tick;
    logic       counter_zero;
    logic [3:0] cnt_data;
    logic       cnt_loadn;
    logic       cnt_clrn;
    logic       cnt_enable;
    logic       mag_on;
    logic       beep;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode number, digit list and beep count.
    int         m_st;
    int         m_digits[$];
    int         m_beeps;
    logic [3:0] m_data;
    logic       m_loadn;
    logic       m_clrn;

    int         rnd;
    logic       r_tk;
    logic [3:0] r_kd;

    microwave_timer_ctrl #(
        .DONE_TICKS(DONE_TICKS),
        .MAX_DIGITS(MAX_DIGITS)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .door_closed  (door_closed),
        .tick         (tick),
        .counter_zero (counter_zero),
        .cnt_data     (cnt_data),
        .cnt_loadn    (cnt_loadn),
        .cnt_clrn     (cnt_clrn),
        .cnt_enable   (cnt_enable),
        .mag_on       (mag_on),
        .beep         (beep),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_digits.delete();
        m_beeps = 0;
        m_data  = 4'd0;
        m_loadn = 1'b1;
        m_clrn  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("state",      8'(state_out),  8'(m_st));
        chk("cnt_data",   8'(cnt_data),   8'(m_data));
        chk("cnt_loadn",  8'(cnt_loadn),  8'(m_loadn));
        chk("cnt_clrn",   8'(cnt_clrn),   8'(m_clrn));
        chk("mag_on",     8'(mag_on),     8'(m_st == 2));
        chk("beep",       8'(beep),       8'(m_st == 4));
        chk("cnt_enable", 8'(cnt_enable), 8'((m_st == 2) && tick && !counter_zero));
    endtask

    // Apply one clock's worth of inputs to the model, highest priority first.
    task automatic model_step();
        int  prev;
        bit  to_idle;
        prev    = m_st;
        to_idle = 0;
        m_loadn = 1'b1;
        m_clrn  = 1'b1;
        if (clear) begin
            to_idle = 1;
        end else if (!door_closed) begin
            if (m_st == 2) m_st = 3;
        end else if (stop) begin
            if (m_st == 1 || m_st == 3 || m_st == 4) to_idle = 1;
            else if (m_st == 2) m_st = 3;
        end else if (start) begin
            if ((m_st == 1 && !counter_zero) || m_st == 3) m_st = 2;
            else if (m_st == 4) to_idle = 1;
        end else if (key_valid) begin
            if (m_st == 4) begin
                to_idle = 1;
            end else if (m_st <= 1 && key_data <= 9 && m_digits.size() < MAX_DIGITS
                         && (m_digits.size() == 0 || m_digits[$] <= 5)) begin
                m_digits.push_back(int'(key_data));
                m_data  = key_data;
                m_loadn = 1'b0;
                m_st    = 1;
            end
        end
        if (!to_idle && prev == 2 && m_st == 2 && counter_zero) begin
            m_st    = 4;
            m_beeps = 0;
        end else if (!to_idle && prev == 4 && m_st == 4 && tick) begin
            m_beeps++;
            if (m_beeps == DONE_TICKS) to_idle = 1;
        end
        if (to_idle) begin
            m_st    = 0;
            m_digits.delete();
            m_beeps = 0;
            m_clrn  = 1'b0;
        end
    endtask

    // Called on a falling edge: drive, check, advance model, wait one clock.
    task automatic cyc(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sp, input logic cl, input logic tk);
        key_valid = kv;
        key_data  = kd;
        start     = st;
        stop      = sp;
        clear     = cl;
        tick      = tk;
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] k);
        cyc(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    initial begin
        clr          = 1'b1;
        key_valid    = 1'b0;
        key_data     = 4'd0;
        start        = 1'b0;
        stop         = 1'b0;
        clear        = 1'b0;
        door_closed  = 1'b1;
        tick         = 1'b0;
        counter_zero = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        clr = 1'b0;
        idle(2);

        // Three accepted digits, fourth dropped by the digit limit.
        key(4'd1); key(4'd3); key(4'd0); key(4'd5);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Seconds-tens would become 7: second key rejected.
        key(4'd7); key(4'd2);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // 0:05 cook to completion.
        key(4'd0); key(4'd0); key(4'd5);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        counter_zero = 1'b1;
        idle(2);
        for (int i = 0; i < DONE_TICKS; i++) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        counter_zero = 1'b0;
        idle(1);

        // Pause on door, resume, stop twice.
        key(4'd1); key(4'd0); key(4'd0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b0;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Clear beats start in the same cycle.
        key(4'd2);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Start refused with door open, then accepted; async reset mid-cook.
        key(4'd4);
        door_closed = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        tick = 1'b1;
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        clr  = 1'b0;
        tick = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rnd  = int'($urandom_range(0, 19));
            r_tk = ($urandom_range(0, 3) == 0);
            r_kd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
            counter_zero = ($urandom_range(0, 24) == 0);
            if (rnd < 6)
                cyc(1'b1, r_kd, 1'b0, 1'b0, 1'b0, r_tk);
            else if (rnd < 9)
                cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, r_tk);
            else if (rnd == 9)
                cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, r_tk);
            else if (rnd == 10 && $urandom_range(0, 3) == 0)
                cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, r_tk);
            else
                cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, r_tk);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
